// File: rtl/vc_stream_mux_rr.sv
// vc_stream_mux_rr: N-input val/rdy stream mux with round-robin arbitration.
// The granted input is captured into a one-entry output register. Optional
// packet locking keeps the grant on one input until its last beat transfers,
// so multi-beat packets from different sources are never interleaved.
// Legal range for p_ninputs is 2..16.

module vc_stream_mux_rr #(
   parameter int p_nbits   = 32,
   parameter int p_ninputs = 4,
   parameter int p_lock    = 0
)(
   input  logic                           clk,
   input  logic                           reset,
   input  logic [p_ninputs-1:0]           in_val,
   output logic [p_ninputs-1:0]           in_rdy,
   input  logic [p_ninputs*p_nbits-1:0]   in_msg,
   input  logic [p_ninputs-1:0]           in_last,
   output logic                           out_val,
   input  logic                           out_rdy,
   output logic [p_nbits-1:0]             out_msg,
   output logic [$clog2(p_ninputs)-1:0]   out_src,
   output logic                           out_last
);

   localparam int c_sbits = $clog2(p_ninputs);

   // Highest legal input index, used for pointer wrap.
   localparam logic [c_sbits-1:0] c_last_idx = c_sbits'(p_ninputs - 1);

   // Input count at one extra bit of width, used by the rotating scan.
   localparam logic [c_sbits:0] c_nin_w = (c_sbits + 1)'(p_ninputs);

   // Successor index modulo p_ninputs; never produces an out-of-range value
   // even when p_ninputs is not a power of two.
   function automatic logic [c_sbits-1:0] next_idx(input logic [c_sbits-1:0] idx);
      return (idx == c_last_idx) ? '0 : idx + 1'b1;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [c_sbits-1:0]  ptr_reg,   ptr_next;
   logic                lock_reg,  lock_next;
   logic [c_sbits-1:0]  owner_reg, owner_next;

   logic                out_val_reg,  out_val_next;
   logic [p_nbits-1:0]  out_msg_reg,  out_msg_next;
   logic [c_sbits-1:0]  out_src_reg,  out_src_next;
   logic                out_last_reg, out_last_next;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   logic [p_nbits-1:0]  msg_arr [p_ninputs];
   logic [p_ninputs-1:0] grant;
   logic [c_sbits-1:0]  gsel;
   logic                found;
   logic [c_sbits:0]    scan;
   logic                load;
   logic                xfer;
   logic                sel_last;

   // Slice the flat message bus into one lane per input.
   generate
      for (genvar gi = 0; gi < p_ninputs; gi++) begin : g_lane
         assign msg_arr[gi] = in_msg[gi*p_nbits +: p_nbits];
      end
   endgenerate

   // Grant selection: the lock owner when locked, otherwise the first valid
   // input found scanning upward from the priority pointer with wrap.
   always_comb begin
      grant = '0;
      gsel  = '0;
      found = 1'b0;
      scan  = '0;
      if (lock_reg) begin
         grant[owner_reg] = in_val[owner_reg];
         found            = in_val[owner_reg];
         gsel             = owner_reg;
      end else begin
         for (int k = 0; k < p_ninputs; k++) begin
            scan = {1'b0, ptr_reg} + (c_sbits + 1)'(k);
            if (scan >= c_nin_w) begin
               scan = scan - c_nin_w;
            end
            if (!found && in_val[scan[c_sbits-1:0]]) begin
               grant[scan[c_sbits-1:0]] = 1'b1;
               gsel                     = scan[c_sbits-1:0];
               found                    = 1'b1;
            end
         end
      end
   end

   // The output register can take a new beat when empty or being drained.
   assign load = !out_val_reg || out_rdy;

   // Ready is forced low while reset is held so no beat is handshaken
   // into a register that is being cleared.
   assign in_rdy = reset ? '0 : (grant & {p_ninputs{load}});
   assign xfer   = found && load && !reset;

   // Without locking every beat is a complete packet.
   assign sel_last = (p_lock != 0) ? in_last[gsel] : 1'b1;

   // Next priority pointer and lock state after a transfer.
   always_comb begin
      ptr_next   = ptr_reg;
      lock_next  = lock_reg;
      owner_next = owner_reg;
      if (xfer) begin
         if (p_lock == 0) begin
            ptr_next = next_idx(gsel);
         end else if (lock_reg) begin
            if (sel_last) begin
               lock_next = 1'b0;
               ptr_next  = next_idx(owner_reg);
            end
         end else if (!sel_last) begin
            lock_next  = 1'b1;
            owner_next = gsel;
         end else begin
            ptr_next = next_idx(gsel);
         end
      end
   end

   // Next output register contents: capture on transfer, empty on drain,
   // otherwise hold (which also covers backpressure).
   always_comb begin
      out_val_next  = out_val_reg;
      out_msg_next  = out_msg_reg;
      out_src_next  = out_src_reg;
      out_last_next = out_last_reg;
      if (xfer) begin
         out_val_next  = 1'b1;
         out_msg_next  = msg_arr[gsel];
         out_src_next  = gsel;
         out_last_next = sel_last;
      end else if (out_rdy) begin
         out_val_next  = 1'b0;
      end
   end

   // Arbitration state registers; reset drops any lock mid-packet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_reg   <= '0;
         lock_reg  <= 1'b0;
         owner_reg <= '0;
      end else begin
         ptr_reg   <= ptr_next;
         lock_reg  <= lock_next;
         owner_reg <= owner_next;
      end
   end

   // Output pipeline register; reset discards any in-flight beat.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_val_reg  <= 1'b0;
         out_msg_reg  <= '0;
         out_src_reg  <= '0;
         out_last_reg <= 1'b0;
      end else begin
         out_val_reg  <= out_val_next;
         out_msg_reg  <= out_msg_next;
         out_src_reg  <= out_src_next;
         out_last_reg <= out_last_next;
      end
   end

   assign out_val  = out_val_reg;
   assign out_msg  = out_msg_reg;
   assign out_src  = out_src_reg;
   assign out_last = out_last_reg;

   // ---------------------------------------------------------------------
   // Simulation checks
   // ---------------------------------------------------------------------
   a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
      $onehot0(grant));

   a_hold_stable: assert property (@(posedge clk) disable iff (reset)
      (out_val_reg && !out_rdy) |=> $stable(out_msg_reg));

   a_val_known: assert property (@(posedge clk) disable iff (reset)
      !$isunknown(out_val_reg));

endmodule

// File: tb/tb_vc_stream_mux_rr.sv
// Testbench for vc_stream_mux_rr: three instances (unlocked 4-input,
// locked 4-input, locked 3-input) driven by directed vectors. Expected
// beats are queued at stimulus time and popped by per-instance monitors.

module tb_vc_stream_mux_rr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // instance 0: p_lock=0, 4 inputs
   logic        rst0, ordy0, oval0, olast0;
   logic [3:0]  val0, irdy0, last0;
   logic [31:0] msg0;
   logic [7:0]  omsg0;
   logic [1:0]  osrc0;

   // instance 1: p_lock=1, 4 inputs
   logic        rst1, ordy1, oval1, olast1;
   logic [3:0]  val1, irdy1, last1;
   logic [31:0] msg1;
   logic [7:0]  omsg1;
   logic [1:0]  osrc1;

   // instance 2: p_lock=1, 3 inputs
   logic        rst2, ordy2, oval2, olast2;
   logic [2:0]  val2, irdy2, last2;
   logic [23:0] msg2;
   logic [7:0]  omsg2;
   logic [1:0]  osrc2;

   logic [10:0] q0[$];
   logic [10:0] q1[$];
   logic [10:0] q2[$];
   logic [10:0] e0, e1, e2;

   vc_stream_mux_rr #(.p_nbits(8), .p_ninputs(4), .p_lock(0)) dut0 (
      .clk(clk), .reset(rst0), .in_val(val0), .in_rdy(irdy0), .in_msg(msg0),
      .in_last(last0), .out_val(oval0), .out_rdy(ordy0), .out_msg(omsg0),
      .out_src(osrc0), .out_last(olast0));

   vc_stream_mux_rr #(.p_nbits(8), .p_ninputs(4), .p_lock(1)) dut1 (
      .clk(clk), .reset(rst1), .in_val(val1), .in_rdy(irdy1), .in_msg(msg1),
      .in_last(last1), .out_val(oval1), .out_rdy(ordy1), .out_msg(omsg1),
      .out_src(osrc1), .out_last(olast1));

   vc_stream_mux_rr #(.p_nbits(8), .p_ninputs(3), .p_lock(1)) dut2 (
      .clk(clk), .reset(rst2), .in_val(val2), .in_rdy(irdy2), .in_msg(msg2),
      .in_last(last2), .out_val(oval2), .out_rdy(ordy2), .out_msg(omsg2),
      .out_src(osrc2), .out_last(olast2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [10:0] ent(input logic [1:0] s, input logic [7:0] m, input logic l);
      return {s, m, l};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // monitors: a beat leaves the DUT on an edge where out_val & out_rdy
   always @(negedge clk) begin
      if (!rst0 && oval0 && ordy0) begin
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL mon0_unexpected actual=src%0d/%0h required=none", osrc0, omsg0);
         end else begin
            e0 = q0.pop_front();
            $display("txn dut0 src=%0d msg=%0h last=%0d", osrc0, omsg0, olast0);
            check("mon0_beat", {21'd0, osrc0, omsg0, olast0}, {21'd0, e0});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst1 && oval1 && ordy1) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL mon1_unexpected actual=src%0d/%0h required=none", osrc1, omsg1);
         end else begin
            e1 = q1.pop_front();
            $display("txn dut1 src=%0d msg=%0h last=%0d", osrc1, omsg1, olast1);
            check("mon1_beat", {21'd0, osrc1, omsg1, olast1}, {21'd0, e1});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst2 && oval2 && ordy2) begin
         if (q2.size() == 0) begin
            total++; bad++;
            $display("FAIL mon2_unexpected actual=src%0d/%0h required=none", osrc2, omsg2);
         end else begin
            e2 = q2.pop_front();
            $display("txn dut2 src=%0d msg=%0h last=%0d", osrc2, omsg2, olast2);
            check("mon2_beat", {21'd0, osrc2, omsg2, olast2}, {21'd0, e2});
         end
      end
   end

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
      val0 = 4'hF; msg0 = 32'h13121110; last0 = '0; ordy0 = 1'b1;
      val1 = '0;   msg1 = '0;           last1 = '0; ordy1 = 1'b1;
      val2 = '0;   msg2 = '0;           last2 = '0; ordy2 = 1'b1;

      // reset with all inputs valid
      #3;
      check("rst_oval", {31'd0, oval0}, 0);
      check("rst_irdy", {28'd0, irdy0}, 0);
      check("rst_oval_c", {31'd0, oval2}, 0);
      tick;
      tick;
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      #1;
      check("first_grant", {28'd0, irdy0}, 32'b0001);

      // ---------------- instance 0: unlocked round robin ----------------
      q0.push_back(ent(2'd0, 8'h10, 1'b1));
      q0.push_back(ent(2'd1, 8'h11, 1'b1));
      q0.push_back(ent(2'd2, 8'h12, 1'b1));
      q0.push_back(ent(2'd3, 8'h13, 1'b1));
      q0.push_back(ent(2'd0, 8'h10, 1'b1));
      q0.push_back(ent(2'd1, 8'h11, 1'b1));
      for (int i = 0; i < 6; i++) begin
         tick;
         check("nobubble", {31'd0, oval0}, 1);
      end
      // backpressure with src 1 / 0x11 held in the output register
      ordy0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_msg", {24'd0, omsg0}, 32'h11);
         check("bp_src", {30'd0, osrc0}, 1);
         check("bp_irdy", {28'd0, irdy0}, 0);
         tick;
      end
      ordy0 = 1'b1;
      #1;
      check("bp_next", {28'd0, irdy0}, 32'b0100);
      q0.push_back(ent(2'd2, 8'h12, 1'b1));
      tick;
      val0 = '0;
      // single active input 2 with 0xA5
      msg0[23:16] = 8'hA5;
      val0 = 4'b0100;
      #1;
      check("single_irdy", {28'd0, irdy0}, 32'b0100);
      q0.push_back(ent(2'd2, 8'hA5, 1'b1));
      tick;
      val0 = '0;
      check("lat1_val", {31'd0, oval0}, 1);
      check("lat1_msg", {24'd0, omsg0}, 32'hA5);
      tick;
      check("drain_val", {31'd0, oval0}, 0);
      // pointer at 3: grant 3, then wrap to 0
      val0 = 4'b1001;
      #1;
      check("wrap3", {28'd0, irdy0}, 32'b1000);
      q0.push_back(ent(2'd3, 8'h13, 1'b1));
      tick;
      check("wrap0", {28'd0, irdy0}, 32'b0001);
      q0.push_back(ent(2'd0, 8'h10, 1'b1));
      tick;
      val0 = '0;
      #1;
      check("idle_irdy", {28'd0, irdy0}, 0);

      // ---------------- instance 1: packet locking ----------------
      msg1[15:8] = 8'h20;
      val1 = 4'b0010;
      #1;
      check("lk_first", {28'd0, irdy1}, 32'b0010);
      q1.push_back(ent(2'd1, 8'h20, 1'b0));
      tick;
      val1 = 4'b0011;
      msg1[15:8] = 8'h21;
      msg1[7:0]  = 8'h30;
      last1[0]   = 1'b1;
      #1;
      check("lk_hold1", {28'd0, irdy1}, 32'b0010);
      q1.push_back(ent(2'd1, 8'h21, 1'b0));
      tick;
      msg1[15:8] = 8'h22;
      last1[1]   = 1'b1;
      #1;
      check("lk_hold2", {28'd0, irdy1}, 32'b0010);
      q1.push_back(ent(2'd1, 8'h22, 1'b1));
      tick;
      check("lk_release", {28'd0, irdy1}, 32'b0001);
      q1.push_back(ent(2'd0, 8'h30, 1'b1));
      tick;
      val1 = 4'b1000;
      msg1[31:24] = 8'h40;
      #1;
      check("lk_pick3", {28'd0, irdy1}, 32'b1000);
      q1.push_back(ent(2'd3, 8'h40, 1'b0));
      tick;
      val1 = 4'b0001;
      #1;
      check("lk_gap1", {28'd0, irdy1}, 0);
      tick;
      check("lk_gap2", {28'd0, irdy1}, 0);
      val1 = 4'b1001;
      msg1[31:24] = 8'h41;
      last1[3] = 1'b1;
      #1;
      check("lk_resume", {28'd0, irdy1}, 32'b1000);
      q1.push_back(ent(2'd3, 8'h41, 1'b1));
      tick;
      val1 = 4'b0110;
      #1;
      check("lk_ptr0", {28'd0, irdy1}, 32'b0010);
      q1.push_back(ent(2'd1, 8'h22, 1'b1));
      tick;
      val1 = '0;

      // ---------------- instance 2: 3 inputs, reset mid-packet ----------------
      ordy2 = 1'b0;
      msg2[23:16] = 8'h50;
      val2 = 3'b100;
      #1;
      check("c_first", {29'd0, irdy2}, 32'b100);
      tick;
      val2 = 3'b011;
      check("c_loaded", {31'd0, oval2}, 1);
      check("c_loaded_msg", {24'd0, omsg2}, 32'h50);
      #2;
      rst2 = 1'b1;
      #1;
      check("c_async_rst", {31'd0, oval2}, 0);
      check("c_rst_irdy", {29'd0, irdy2}, 0);
      tick;
      rst2 = 1'b0;
      ordy2 = 1'b1;
      msg2[7:0]  = 8'h60;
      msg2[15:8] = 8'h61;
      last2 = 3'b111;
      #1;
      check("c_after_rst", {29'd0, irdy2}, 32'b001);
      q2.push_back(ent(2'd0, 8'h60, 1'b1));
      tick;
      val2 = 3'b100;
      msg2[23:16] = 8'h62;
      #1;
      check("c_pick2", {29'd0, irdy2}, 32'b100);
      q2.push_back(ent(2'd2, 8'h62, 1'b1));
      tick;
      val2 = 3'b111;
      #1;
      check("c_wrap", {29'd0, irdy2}, 32'b001);
      q2.push_back(ent(2'd0, 8'h60, 1'b1));
      tick;
      val2 = '0;

      // let every queued beat drain
      repeat (4) tick;
      check("drain_q0", q0.size(), 0);
      check("drain_q1", q1.size(), 0);
      check("drain_q2", q2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vc_stream_mux_rr.md
Name: vc_stream_mux_rr

Overview:
- Parametrised N-input streaming mux; the successor to the fixed-arity combinational select muxes.
- Instead of an external select, it picks a source by round-robin arbitration over val/rdy input streams.
- The chosen message goes into a one-entry output pipeline register, with optional packet locking so multi-beat transfers are not interleaved.
- Used wherever several request streams share one downstream port (memory request merge, network injection).

Parameters:
- p_nbits, 32: message width in bits.
- p_ninputs, 4: number of input streams; legal range 2..16.
- p_lock, 0: 1 holds the grant on one input until a beat with last=1 transfers; 0 arbitrates every beat.
- Derived, not overridable: c_sbits = $clog2(p_ninputs).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  p_ninputs  per-input valid; bit i belongs to input i.
- in_rdy  output  p_ninputs  per-input ready.
- in_msg  input  p_ninputs*p_nbits  input i occupies bits [i*p_nbits +: p_nbits].
- in_last  input  p_ninputs  end-of-packet flag per input; ignored when p_lock=0.
- out_val  output  1  output register holds a beat.
- out_rdy  input  1  downstream accepts.
- out_msg  output  p_nbits  registered message.
- out_src  output  c_sbits  index of the input that supplied out_msg.
- out_last  output  1  registered last flag.

Behaviour:
- Reset (asynchronous, effective immediately):
  - out_val=0, out_msg=0, out_src=0, out_last=0.
  - Priority pointer ptr=0; lock flag cleared.
  - in_rdy follows the combinational rules below, so in_rdy is 0 while in_val=0 or reset is held.
- Load enable: load = !out_val || out_rdy.
  - Gives full throughput of one beat per cycle.
  - out_rdy feeds in_rdy combinationally (pipe-style).
- Grant (combinational, one-hot or zero):
  - Unlocked: first i with in_val[i]=1, scanning ptr, ptr+1, ..., wrapping mod p_ninputs.
  - Locked: grant only to the lock owner, and only when its in_val=1; all other inputs stall.
- in_rdy[i] = grant[i] & load.
- Transfer on input i: in_val[i] & in_rdy[i]. On the next edge:
  - out_val=1, out_msg=in_msg[i], out_src=i, out_last=in_last[i] (out_last=1 when p_lock=0).
- If out_val & out_rdy and no input transfer occurs: out_val becomes 0 next cycle. out_msg/out_src/out_last hold their stale values; they are don't-care.
- Latency: input transfer to out_val=1 is exactly 1 cycle. Back-to-back transfers with out_rdy=1 sustain 1 beat/cycle.
- Backpressure: while out_val=1 and out_rdy=0, all output fields hold stable and all in_rdy=0.
- Pointer update, p_lock=0: on every transfer from i, ptr <= (i+1) mod p_ninputs.
- Pointer update, p_lock=1:
  - Transfer with last=0 from an unlocked state: set lock, owner=i; ptr unchanged.
  - Transfer with last=1: clear lock; ptr <= (owner+1) mod p_ninputs.
  - A single-beat packet (last=1 on the first beat) never locks.
- Wrap: ptr=p_ninputs-1 followed by a grant to the highest input must wrap ptr to 0.
- Non-power-of-two p_ninputs:
  - ptr never takes values >= p_ninputs.
  - out_src is always < p_ninputs.
- No valid inputs: no grant, all in_rdy=0, ptr and lock unchanged.
- in_val deasserting mid-packet while locked: lock is held and no other input is granted.
- Reset mid-packet: the lock is dropped and the in-flight beat is discarded. Upstream re-sends after reset.
- Assertions (simulation only):
  - grant is one-hot or zero.
  - out_msg stable while out_val & !out_rdy.
  - No X on out_val after reset.

Test Plan (p_nbits=8, p_ninputs=4 unless noted):
- Reset asserted with in_val=4'b1111 -> out_val=0 and ptr=0 immediately. After release, the first grant is to input 0 (in_rdy=4'b0001).
- Only in_val[2]=1, msg 0xA5, out_rdy=1 -> in_rdy=4'b0100. Next cycle out_val=1, out_msg=0xA5, out_src=2.
- All in_val=1, msgs 0x10/0x11/0x12/0x13, out_rdy=1 held -> out_src sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Output full with src=1 msg 0x11, out_rdy=0 for 3 cycles -> out_msg=0x11 stable and in_rdy=0 throughout. When out_rdy=1, the next beat comes from src 2.
- p_lock=1: input 1 alone sends 0x20(last0); input 0 raises val the next cycle; input 1 continues 0x21(last0), 0x22(last1) -> out_src 1,1,1 then 0. in_rdy[0]=0 until 0x22 transfers.
- p_lock=1, p_ninputs=3: reset pulsed after the first beat of a locked packet from input 2 -> out_val=0, lock cleared. Next grant is to the lowest valid index from ptr=0. ptr wraps 2->0 after an input-2 single-beat grant.
